// File: rtl/iob_uart_master.sv
// iob_uart_master: IOb bus initiator that configures an iob_uart and then
// moves bytes between a valid/ready byte stream and the UART data registers.
// Only one bus request is ever outstanding. A fixed priority flag alternates
// between TX and RX service, so neither direction can starve the other.
module iob_uart_master #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 3,
  parameter int SOFTRESET_ADDR = 0,
  parameter int DIV_ADDR       = 1,
  parameter int TXDATA_ADDR    = 2,
  parameter int TXEN_ADDR      = 3,
  parameter int TXREADY_ADDR   = 4,
  parameter int RXDATA_ADDR    = 5,
  parameter int RXEN_ADDR      = 6,
  parameter int RXREADY_ADDR   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [15:0]         cfg_div,
  output logic                init_done,
  input  logic [7:0]          tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [7:0]          rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SCHED, S_POLL_TX, S_WR_TX, S_POLL_RX, S_RD_RX
  } state_t;

  localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(SOFTRESET_ADDR);
  localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(DIV_ADDR);
  localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(TXDATA_ADDR);
  localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(TXEN_ADDR);
  localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(TXREADY_ADDR);
  localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(RXDATA_ADDR);
  localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(RXEN_ADDR);
  localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(RXREADY_ADDR);

  localparam logic [2:0] LAST_INIT_STEP = 3'd4;

  state_t                r_state;
  logic [2:0]            r_init_step;
  logic [15:0]           r_div;
  logic [7:0]            r_tx_byte;
  logic                  r_prio_tx;     // 1: TX has priority, 0: RX has priority
  logic                  r_init_done;
  logic                  r_tx_ready;
  logic [7:0]            r_rx_data;
  logic                  r_rx_valid;
  logic                  r_m_valid;
  logic [ADDR_W-1:0]     r_m_address;
  logic [DATA_W-1:0]     r_m_wdata;
  logic [DATA_W/8-1:0]   r_m_wstrb;

  logic                  w_req_en;
  logic                  w_req_wr;
  logic [ADDR_W-1:0]     w_req_addr;
  logic [15:0]           w_req_data;
  logic                  w_ack;
  logic                  w_rd_bit;

  assign w_ack    = r_m_valid & m_ready;
  assign w_rd_bit = m_rdata[0];

  // Decode the bus request that the current state wants to issue.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    w_req_en   = 1'b1;
    w_req_wr   = 1'b0;
    w_req_addr = '0;
    w_req_data = '0;
    case (r_state)
      S_INIT: begin
        w_req_wr = 1'b1;
        case (r_init_step)
          3'd0:    begin w_req_addr = A_SOFTRESET; w_req_data = 16'd1; end
          3'd1:    begin w_req_addr = A_SOFTRESET; w_req_data = 16'd0; end
          3'd2:    begin w_req_addr = A_DIV;       w_req_data = r_div; end
          3'd3:    begin w_req_addr = A_TXEN;      w_req_data = 16'd1; end
          default: begin w_req_addr = A_RXEN;      w_req_data = 16'd1; end
        endcase
      end
      S_POLL_TX: w_req_addr = A_TXREADY;
      S_WR_TX: begin
        w_req_wr   = 1'b1;
        w_req_addr = A_TXDATA;
        w_req_data = {8'd0, r_tx_byte};
      end
      S_POLL_RX: w_req_addr = A_RXREADY;
      S_RD_RX:   w_req_addr = A_RXDATA;
      default:   w_req_en = 1'b0;
    endcase
  end

  // Main FSM: bus request/response handling, scheduling and the RX buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_init_step <= '0;
      r_div       <= '0;
      r_tx_byte   <= '0;
      r_prio_tx   <= 1'b0;
      r_init_done <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_m_valid   <= 1'b0;
      r_m_address <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // state as it was at the clock edge regardless of statement order.
      r_tx_ready <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

      // A request is held until acknowledged, then the bus idles one cycle.
      if (w_ack) begin
        r_m_valid   <= 1'b0;
        r_m_address <= '0;
        r_m_wdata   <= '0;
        r_m_wstrb   <= '0;
      end else if (w_req_en && !r_m_valid) begin
        r_m_valid   <= 1'b1;
        r_m_address <= w_req_addr;
        r_m_wdata   <= DATA_W'(w_req_data);
        r_m_wstrb   <= w_req_wr ? '1 : '0;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_div       <= cfg_div;
            r_init_step <= '0;
            r_state     <= S_INIT;
          end
        end
        S_INIT: begin
          if (w_ack) begin
            if (r_init_step == LAST_INIT_STEP) begin
              r_init_done <= 1'b1;
              r_state     <= S_SCHED;
            end else begin
              r_init_step <= r_init_step + 3'd1;
            end
          end
        end
        S_SCHED: begin
          if (cfg_start) begin
            r_rx_valid  <= 1'b0;
            r_init_done <= 1'b0;
            r_div       <= cfg_div;
            r_init_step <= '0;
            r_state     <= S_INIT;
          end else if (tx_valid && (r_prio_tx || r_rx_valid)) begin
            r_tx_byte  <= tx_data;
            r_tx_ready <= 1'b1;
            r_state    <= S_POLL_TX;
          end else if (!r_rx_valid) begin
            r_state <= S_POLL_RX;
          end
        end
        S_POLL_TX: begin
          if (w_ack && w_rd_bit) r_state <= S_WR_TX;
        end
        S_WR_TX: begin
          if (w_ack) begin
            r_prio_tx <= 1'b0;
            r_state   <= S_SCHED;
          end
        end
        S_POLL_RX: begin
          if (w_ack) begin
            if (w_rd_bit) begin
              r_state <= S_RD_RX;
            end else begin
              r_prio_tx <= 1'b1;
              r_state   <= S_SCHED;
            end
          end
        end
        S_RD_RX: begin
          if (w_ack) begin
            r_rx_data  <= m_rdata[7:0];
            r_rx_valid <= 1'b1;
            r_prio_tx  <= 1'b1;
            r_state    <= S_SCHED;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign init_done = r_init_done;
  assign tx_ready  = r_tx_ready;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign m_valid   = r_m_valid;
  assign m_address = r_m_address;
  assign m_wdata   = r_m_wdata;
  assign m_wstrb   = r_m_wstrb;

endmodule

// File: doc/iob_uart_master.md
Name: iob_uart_master

Overview:
Hardware bus initiator that drives an iob_uart register interface over the IOb native bus, so no CPU is needed.
- Runs a configuration sequence: soft reset, divider, TX/RX enable.
- Then moves bytes from a valid/ready byte input to the UART TX register.
- Polls the UART RX register into a one-entry valid/ready byte output.
- Sits between a hardware stream source/sink (e.g. boot loader, debug bridge) and the UART peripheral's slave port.

Parameters:
DATA_W, 32, bus data width (32 or 64)
ADDR_W, 3, bus address width
SOFTRESET_ADDR, 0, address of UART soft-reset register
DIV_ADDR, 1, address of UART divider register
TXDATA_ADDR, 2, address of UART TX data register
TXEN_ADDR, 3, address of UART TX enable register
TXREADY_ADDR, 4, address of UART TX ready register
RXDATA_ADDR, 5, address of UART RX data register
RXEN_ADDR, 6, address of UART RX enable register
RXREADY_ADDR, 7, address of UART RX ready register

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cfg_start  in  1  pulse: start or restart the configuration sequence
cfg_div  in  16  baud divider, sampled on accepted cfg_start
init_done  out  1  high once configuration is complete, until the next restart
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  one-cycle pulse: byte accepted
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid (buffer full)
rx_ready  in  1  consumer accepts rx_data
m_valid  out  1  bus request
m_address  out  ADDR_W  bus address
m_wdata  out  DATA_W  write data, zero-extended
m_wstrb  out  DATA_W/8  all ones for writes, all zeros for reads
m_rdata  in  DATA_W  read data, valid when m_ready is high
m_ready  in  1  bus response, one cycle per request

Behaviour:
- Reset (asynchronous): every output is 0, the FSM goes to IDLE, the RX buffer is emptied, and the priority flag is set to RX. An in-flight request is dropped immediately.
- Bus rules:
  - On issue, m_valid rises with address, wdata and wstrb stable.
  - All four are held until the cycle m_ready is sampled high.
  - m_valid is 0 the following cycle; at most one request is outstanding.
  - While m_valid is low, m_address, m_wdata and m_wstrb are 0.
  - Minimum request length is 1 cycle; a 0-wait-state responder gives 2 cycles per transaction.
- States: IDLE, INIT, SCHED, POLL_TX, WR_TX, POLL_RX, RD_RX.
- IDLE: waits for cfg_start, latches cfg_div, then goes to INIT.
- INIT: issues five writes in order, each completing before the next:
  1. SOFTRESET=1
  2. SOFTRESET=0
  3. DIV=cfg_div
  4. TXEN=1
  5. RXEN=1
  After write 5 is acknowledged, init_done=1 and the FSM goes to SCHED.
- SCHED (one cycle decision point):
  - cfg_start high: empty the RX buffer, clear init_done, latch cfg_div, go to INIT. This takes precedence over all other cases.
  - tx_valid=1 and (priority=TX, or RX buffer full): latch tx_data, pulse tx_ready, go to POLL_TX.
  - Else if RX buffer empty: go to POLL_RX.
  - Else stay in SCHED.
- POLL_TX: reads TXREADY.
  - rdata[0]=0: re-read immediately, with one idle cycle between requests.
  - rdata[0]=1: go to WR_TX.
- WR_TX: writes the latched byte to TXDATA. On ack, set priority=RX and go to SCHED.
- POLL_RX: reads RXREADY.
  - rdata[0]=0: set priority=TX and go to SCHED (one poll per visit; TX is never starved).
  - rdata[0]=1: go to RD_RX.
- RD_RX: reads RXDATA. On ack, load rdata[7:0] into the buffer, set rx_valid=1, set priority=TX, go to SCHED.
- RX buffer: rx_valid clears the cycle after rx_valid&rx_ready. A refill is only started from SCHED with the buffer empty, so load and drain never coincide.
- cfg_start outside IDLE and SCHED is ignored (not queued).
- Edge cases:
  - tx_valid dropping after tx_ready has no effect; the byte is already latched.
  - cfg_div=0 is passed through unchanged.

Test Plan:
1. Reset, then cfg_start with cfg_div=16'h01B2 and a 0-wait responder -> writes, in order: (0,1), (0,0), (1,0x1B2), (3,1), (6,1); all wstrb=F; init_done=1 after the 5th ack; m_valid never high two consecutive requests without a gap.
2. tx_data=8'h55, tx_valid=1; TXREADY reads 0,0,1 -> one tx_ready pulse, three reads at address 4, then write (2,0x55), then priority moves to RX.
3. RXREADY=1 and RXDATA=0xA7 with rx_ready=0 -> rx_valid=1, rx_data=0xA7, no further RX reads; with tx_valid=1 the TX path runs; rx_ready=1 -> rx_valid drops next cycle and polling resumes.
4. tx_valid held high continuously and RXREADY=1 always -> bus alternates TX write and RX read; neither starves over 8 bytes each.
5. Assert rst while m_valid=1 mid-POLL_TX with m_ready withheld -> m_valid=0 immediately, init_done=0, and no bus activity until cfg_start.
6. cfg_start during POLL_RX -> ignored; cfg_start in SCHED with rx_valid=1 -> rx_valid=0 and the INIT sequence reissued with the new cfg_div.
